bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_if.sv | 24 ++
 rtl/bit_serializer.sv | 102 ++++++++++
 tb/tb_bit_serializer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// bit_serializer_if -- load/serial bundle for bit_serializer.
//   load_valid / load_data / load_ready : parallel word handshake (upstream -> serializer)
//   out_bit / out_valid / frame_done    : serial output stream (serializer -> downstream)
// master: the upstream/downstream environment; slave: the serializer itself.
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             out_bit;
  logic             out_valid;
  logic             frame_done;

  modport master (
    output load_valid, load_data,
    input  load_ready, out_bit, out_valid, frame_done
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, out_bit, out_valid, frame_done
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer -- parallel-to-serial converter, MSB first, one bit per clock.
// Ports:
//   clock       single rising-edge clock
//   reset       synchronous active-high reset
//   bus (slave) load_valid/load_data/load_ready handshake in,
//               out_bit/out_valid/frame_done registered serial stream out
// A one-word hold buffer lets the next word be accepted mid-frame so that
// back-to-back frames leave the serial line with no idle gap.
module bit_serializer #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  bit_serializer_if.slave bus
);
  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_bit_q, out_valid_q, frame_done_q;
  logic             accept;

  assign bus.load_ready = !hold_full_q && !reset;
  assign accept         = bus.load_valid && bus.load_ready;

  // cnt_q is the index (0 = MSB) of the bit currently on out_bit.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Frame boundary: a held word has priority; otherwise a word
          // accepted on this very edge is loaded directly.
          cnt_d = '0;
          if (hold_full_q) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shreg_d = bus.load_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + ONE;
          if (accept) begin
            hold_d      = bus.load_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so the bit on the
  // line always corresponds to the state held in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      out_bit_q    <= IDLE_BIT;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= (state_d == SHIFT);
      out_bit_q    <= (state_d == SHIFT) ? shreg_d[WIDTH-1] : IDLE_BIT;
      frame_done_q <= (state_d == SHIFT) && (cnt_d == LAST);
    end
  end

  assign bus.out_bit    = out_bit_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer -- randomized + directed bench for bit_serializer (WIDTH=8).
// Reference model: the serializer is viewed as a FIFO of pending bits. A word
// can be taken whenever fewer than WIDTH bits wait behind the one on the line;
// each edge appends accepted words and moves the next bit onto the line.
// Expected bits also go into a scoreboard queue that a separate monitor pops
// whenever the DUT shows out_valid.
module tb_bit_serializer;
  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  bit_serializer_if #(.WIDTH(WIDTH)) bus  ();
  bit_serializer_if #(.WIDTH(WIDTH)) bus1 ();

  bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Second instance with IDLE_BIT=1 that never receives a word.
  bit_serializer #(.WIDTH(WIDTH), .IDLE_BIT(1'b1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  always #5 clock = ~clock;

  exp_t mq[$];     // timing model: bits still to be put on the line
  exp_t sb[$];     // scoreboard: expected bits in output order
  logic exp_ready  = 1'b0;
  logic exp_valid  = 1'b0;
  logic checking   = 1'b0;
  int   errors     = 0;
  int   checks     = 0;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, advance through the rising edge, update model.
  task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] d,
                     output logic accepted);
    exp_t e;
    reset          = r;
    bus.load_valid = v;
    bus.load_data  = d;
    exp_ready      = !r && (mq.size() < WIDTH);
    accepted       = v && exp_ready;
    @(posedge clock);
    if (r) begin
      mq.delete();
      sb.delete();
      exp_valid = 1'b0;
      checking  = 1'b1;
    end else begin
      if (accepted) begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          e.b    = d[i];
          e.last = (i == 0);
          mq.push_back(e);
          sb.push_back(e);
        end
      end
      if (mq.size() > 0) begin
        void'(mq.pop_front());
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int unsigned n);
    logic a;
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, a);
  endtask

  // Monitor: compares at the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (checking) begin
      check("load_ready", bus.load_ready, exp_ready);
      check("out_valid", bus.out_valid, exp_valid);
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got out_valid=1 expected no pending bit at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("out_bit", bus.out_bit, e.b);
          check("frame_done", bus.frame_done, e.last);
        end
      end else begin
        check("idle_out_bit", bus.out_bit, 1'b0);
        check("idle_frame_done", bus.frame_done, 1'b0);
      end
      check("idle1_out_bit", bus1.out_bit, 1'b1);
      check("idle1_out_valid", bus1.out_valid, 1'b0);
      check("idle1_frame_done", bus1.frame_done, 1'b0);
    end
  end

  initial begin
    logic a;
    int unsigned tries;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus1.load_valid = 1'b0;
    bus1.load_data  = '0;

    // Reset, with load_valid asserted to show it is ignored.
    cyc(1'b1, 1'b1, 8'h55, a);
    cyc(1'b1, 1'b0, '0, a);

    // Single frame 0x18.
    cyc(1'b0, 1'b1, 8'h18, a);
    idle(10);

    // A5 then 3C two cycles later, then FF held on load_valid until taken.
    cyc(1'b0, 1'b1, 8'hA5, a);
    cyc(1'b0, 1'b0, '0, a);
    cyc(1'b0, 1'b1, 8'h3C, a);
    tries = 0;
    a     = 1'b0;
    while (!a && tries < 20) begin
      cyc(1'b0, 1'b1, 8'hFF, a);
      tries++;
    end
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL ff_accept_timeout: got no accept expected accept within 20 cycles");
    end
    idle(30);

    // 0F, then F0 offered exactly on the edge ending 0F's LSB.
    cyc(1'b0, 1'b1, 8'h0F, a);
    idle(7);
    cyc(1'b0, 1'b1, 8'hF0, a);
    idle(12);

    // FF with 81 held; reset while the 4th bit of FF is on the line.
    cyc(1'b0, 1'b1, 8'hFF, a);
    cyc(1'b0, 1'b1, 8'h81, a);
    idle(2);
    cyc(1'b1, 1'b0, '0, a);
    idle(12);

    // Random traffic with occasional resets.
    for (int unsigned i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 79) == 0),
          ($urandom_range(0, 2) != 0),
          WIDTH'($urandom), a);
    end
    idle(2 * WIDTH + 4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending bits expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
